// File: rtl/chroma_job_ctrl.sv
// Job scheduler for the chroma datapath: splits one copy job into chunks and
// sequences write-mover arm, read-mover arm and beat drain for each chunk.
module chroma_job_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 64,
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned CHUNK_BYTES = 128,
  parameter int unsigned TIMEOUT     = 1024,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_src,
  input  logic [ADDR_WIDTH-1:0] cmd_dst,
  input  logic [ADDR_WIDTH-1:0] cmd_len,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [ADDR_WIDTH-1:0] rd_src,
  output logic [ADDR_WIDTH-1:0] rd_len,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [ADDR_WIDTH-1:0] wr_dest,
  input  logic                  out_beat,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            err_code,
  output logic [CNT_WIDTH-1:0]  chunks_done
);

  localparam int unsigned BEAT_BYTES = DATA_WIDTH / 8;
  localparam int unsigned BEAT_SHIFT = $clog2(BEAT_BYTES);

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_BAD_LEN = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE_WR,
    S_ISSUE_RD,
    S_WAIT,
    S_ADVANCE
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] src_q;
  logic [ADDR_WIDTH-1:0] dst_q;
  logic [ADDR_WIDTH-1:0] rem_q;
  logic [CNT_WIDTH-1:0]  beat_cnt_q;
  logic [CNT_WIDTH-1:0]  tmo_q;

  logic                  cmd_ready_q;
  logic                  rd_valid_q;
  logic [ADDR_WIDTH-1:0] rd_src_q;
  logic [ADDR_WIDTH-1:0] rd_len_q;
  logic                  wr_valid_q;
  logic [ADDR_WIDTH-1:0] wr_dest_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;
  logic [1:0]            err_code_q;
  logic [CNT_WIDTH-1:0]  chunks_done_q;

  logic [ADDR_WIDTH-1:0] chunk_len_c;
  logic [CNT_WIDTH-1:0]  beat_tgt_c;
  logic                  len_bad_c;
  logic                  last_chunk_c;
  logic                  wait_exit_c;
  logic                  beat_take_c;

  // Current chunk geometry, derived from the bytes still to move.
  always_comb begin
    chunk_len_c  = (rem_q < ADDR_WIDTH'(CHUNK_BYTES)) ? rem_q : ADDR_WIDTH'(CHUNK_BYTES);
    beat_tgt_c   = CNT_WIDTH'(chunk_len_c >> BEAT_SHIFT);
    last_chunk_c = (rem_q == chunk_len_c);
    len_bad_c    = (cmd_len == '0) || ((cmd_len & ADDR_WIDTH'(BEAT_BYTES - 1)) != '0);
    wait_exit_c  = (beat_cnt_q == beat_tgt_c) && wr_ready;
    beat_take_c  = out_beat && (beat_cnt_q < beat_tgt_c);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      src_q         <= '0;
      dst_q         <= '0;
      rem_q         <= '0;
      beat_cnt_q    <= '0;
      tmo_q         <= '0;
      cmd_ready_q   <= 1'b1;
      rd_valid_q    <= 1'b0;
      rd_src_q      <= '0;
      rd_len_q      <= '0;
      wr_valid_q    <= 1'b0;
      wr_dest_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      err_code_q    <= ERR_NONE;
      chunks_done_q <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            src_q         <= cmd_src;
            dst_q         <= cmd_dst;
            rem_q         <= cmd_len;
            chunks_done_q <= '0;
            if (len_bad_c) begin
              err_q      <= 1'b1;
              err_code_q <= ERR_BAD_LEN;
            end else begin
              err_code_q  <= ERR_NONE;
              busy_q      <= 1'b1;
              cmd_ready_q <= 1'b0;
              wr_valid_q  <= 1'b1;
              wr_dest_q   <= cmd_dst;
              state_q     <= S_ISSUE_WR;
            end
          end
        end

        // Writer is armed first so converter output always has a sink.
        S_ISSUE_WR: begin
          if (wr_ready) begin
            wr_valid_q <= 1'b0;
            rd_valid_q <= 1'b1;
            rd_src_q   <= src_q;
            rd_len_q   <= chunk_len_c;
            state_q    <= S_ISSUE_RD;
          end
        end

        S_ISSUE_RD: begin
          if (rd_ready) begin
            rd_valid_q <= 1'b0;
            beat_cnt_q <= '0;
            tmo_q      <= '0;
            state_q    <= S_WAIT;
          end
        end

        // Drain: all beats seen and the writer back to idle.
        S_WAIT: begin
          if (wait_exit_c) begin
            chunks_done_q <= chunks_done_q + CNT_WIDTH'(1);
            done_q        <= last_chunk_c;
            state_q       <= S_ADVANCE;
          end else if (beat_take_c) begin
            beat_cnt_q <= beat_cnt_q + CNT_WIDTH'(1);
            tmo_q      <= '0;
          end else if (tmo_q == CNT_WIDTH'(TIMEOUT - 1)) begin
            err_q       <= 1'b1;
            err_code_q  <= ERR_TIMEOUT;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end else begin
            tmo_q <= tmo_q + CNT_WIDTH'(1);
          end
        end

        S_ADVANCE: begin
          src_q <= src_q + chunk_len_c;
          dst_q <= dst_q + chunk_len_c;
          rem_q <= rem_q - chunk_len_c;
          if (last_chunk_c) begin
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end else begin
            wr_valid_q <= 1'b1;
            wr_dest_q  <= dst_q + chunk_len_c;
            state_q    <= S_ISSUE_WR;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rd_valid    = rd_valid_q;
  assign rd_src      = rd_src_q;
  assign rd_len      = rd_len_q;
  assign wr_valid    = wr_valid_q;
  assign wr_dest     = wr_dest_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign err_code    = err_code_q;
  assign chunks_done = chunks_done_q;

endmodule
